// File: rtl/multicore_shared_ram.sv
// rtl/multicore_shared_ram.sv - dual Avalon-MM port shared RAM with arbiter and pipelined reads
// Define MULTICORE_SHARED_RAM_PARITY_EN to store and check per-byte even parity.
module multicore_shared_ram #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int DEPTH          = 1024,
  parameter int READ_LATENCY   = 1,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic [DATA_WIDTH/8-1:0] a_byteenable,
  input  logic                    a_chipselect,
  input  logic                    a_read,
  input  logic                    a_write,
  input  logic [DATA_WIDTH-1:0]   a_writedata,
  output logic [DATA_WIDTH-1:0]   a_readdata,
  output logic                    a_readdatavalid,
  output logic                    a_waitrequest,
  output logic                    a_parity_err,
  input  logic [ADDR_WIDTH-1:0]   b_address,
  input  logic [DATA_WIDTH/8-1:0] b_byteenable,
  input  logic                    b_chipselect,
  input  logic                    b_read,
  input  logic                    b_write,
  input  logic [DATA_WIDTH-1:0]   b_writedata,
  output logic [DATA_WIDTH-1:0]   b_readdata,
  output logic                    b_readdatavalid,
  output logic                    b_waitrequest,
  output logic                    b_parity_err
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];

  logic stall, req_a, req_b, grant_a, grant_b, contested;
  logic prio_q, prio_d;

  always_comb begin
    stall = ~clken | reset_req;
    req_a = a_chipselect & (a_read | a_write);
    req_b = b_chipselect & (b_read | b_write);
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset && !stall) begin
      if (req_a && req_b) begin
        if (FIXED_PRIORITY != 0 || !prio_q) grant_a = 1'b1;
        else grant_b = 1'b1;
      end else begin
        grant_a = req_a;
        grant_b = req_b;
      end
    end
    contested = req_a & req_b & (grant_a | grant_b);
    prio_d = (FIXED_PRIORITY == 0 && contested) ? ~prio_q : prio_q;
  end

  assign a_waitrequest = req_a & ~grant_a;
  assign b_waitrequest = req_b & ~grant_b;

  logic                  acc_valid, acc_write, acc_port, acc_in_range, rd_accept;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [IDX_W-1:0]      acc_idx;
  logic [NB-1:0]         acc_be, wr_lane;
  logic [DATA_WIDTH-1:0] acc_wdata, rd_word;
  logic                  rd_err;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_comb begin
    acc_valid    = grant_a | grant_b;
    acc_port     = grant_b;
    acc_addr     = grant_b ? b_address : a_address;
    acc_be       = grant_b ? b_byteenable : a_byteenable;
    acc_wdata    = grant_b ? b_writedata : a_writedata;
    acc_write    = grant_b ? b_write : a_write;
    acc_in_range = ({1'b0, acc_addr} < DEPTH_W);
    acc_idx      = acc_addr[IDX_W-1:0];
    rd_accept    = acc_valid & ~acc_write;
    wr_lane      = (acc_valid && acc_write && acc_in_range) ? acc_be : '0;
    rd_word      = acc_in_range ? mem[acc_idx] : '0;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_lane[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
    end
  end

`ifdef MULTICORE_SHARED_RAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] rd_par, par_calc;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_lane[i]) par_mem[acc_idx][i] <= ^acc_wdata[8*i +: 8];
    end
  end

  always_comb begin
    rd_par = acc_in_range ? par_mem[acc_idx] : '0;
    for (int i = 0; i < NB; i++) par_calc[i] = ^rd_word[8*i +: 8];
    rd_err = acc_in_range & (|((par_calc ^ rd_par) & acc_be));
  end
`else
  assign rd_err = 1'b0;
`endif

  // Stage 1 doubles as the memory output register; it freezes while stalled.
  logic                  s1_valid_q, s1_valid_d, s1_port_q, s1_port_d, s1_err_q, s1_err_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_port_d  = s1_port_q;
    s1_err_d   = s1_err_q;
    s1_data_d  = s1_data_q;
    if (!stall) begin
      s1_valid_d = rd_accept;
      if (rd_accept) begin
        s1_port_d = acc_port;
        s1_err_d  = rd_err;
        s1_data_d = rd_word;
      end
    end
  end

  logic                  out_valid, out_port, out_err;
  logic [DATA_WIDTH-1:0] out_data;

  generate
    if (READ_LATENCY == 2) begin : g_rl2
      logic                  s2_valid_q, s2_valid_d, s2_port_q, s2_port_d, s2_err_q, s2_err_d;
      logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;

      always_comb begin
        s2_valid_d = s2_valid_q;
        s2_port_d  = s2_port_q;
        s2_err_d   = s2_err_q;
        s2_data_d  = s2_data_q;
        if (!stall) begin
          s2_valid_d = s1_valid_q;
          if (s1_valid_q) begin
            s2_port_d = s1_port_q;
            s2_err_d  = s1_err_q;
            s2_data_d = s1_data_q;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          s2_valid_q <= 1'b0;
          s2_port_q  <= 1'b0;
          s2_err_q   <= 1'b0;
          s2_data_q  <= '0;
        end else begin
          s2_valid_q <= s2_valid_d;
          s2_port_q  <= s2_port_d;
          s2_err_q   <= s2_err_d;
          s2_data_q  <= s2_data_d;
        end
      end

      assign out_valid = s2_valid_q;
      assign out_port  = s2_port_q;
      assign out_err   = s2_err_q;
      assign out_data  = s2_data_q;
    end else begin : g_rl1
      assign out_valid = s1_valid_q;
      assign out_port  = s1_port_q;
      assign out_err   = s1_err_q;
      assign out_data  = s1_data_q;
    end
  endgenerate

  // The final stage is presented for exactly one un-stalled, non-reset cycle.
  logic                  deliver_a, deliver_b;
  logic [DATA_WIDTH-1:0] rda_q, rda_d, rdb_q, rdb_d;

  always_comb begin
    deliver_a = out_valid & ~stall & ~reset & ~out_port;
    deliver_b = out_valid & ~stall & ~reset & out_port;
    rda_d = deliver_a ? out_data : rda_q;
    rdb_d = deliver_b ? out_data : rdb_q;
  end

  assign a_readdatavalid = deliver_a;
  assign b_readdatavalid = deliver_b;
  assign a_readdata      = rda_d;
  assign b_readdata      = rdb_d;
  assign a_parity_err    = deliver_a & out_err;
  assign b_parity_err    = deliver_b & out_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_port_q  <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_data_q  <= '0;
      rda_q      <= '0;
      rdb_q      <= '0;
    end else begin
      prio_q     <= prio_d;
      s1_valid_q <= s1_valid_d;
      s1_port_q  <= s1_port_d;
      s1_err_q   <= s1_err_d;
      s1_data_q  <= s1_data_d;
      rda_q      <= rda_d;
      rdb_q      <= rdb_d;
    end
  end
endmodule

// File: tb/tb_multicore_shared_ram.sv
// tb/tb_multicore_shared_ram.sv - scoreboard bench for multicore_shared_ram
// u0: defaults (RL=1, round-robin, 1024 words); u1: RL=2, fixed priority, 512 words.
`timescale 1ns/1ps
module tb_multicore_shared_ram;
  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ck_en  [2];
  logic        rreq   [2];
  logic        cs     [2][2];
  logic        rd     [2][2];
  logic        wr     [2][2];
  logic [9:0]  addr   [2][2];
  logic [3:0]  be     [2][2];
  logic [31:0] wd     [2][2];
  logic [31:0] rdata  [2][2];
  logic        rvalid [2][2];
  logic        wreq   [2][2];
  logic        perr   [2][2];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   k0;
  exp_t sbq [4][$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multicore_shared_ram u0 (
    .clk(clk), .reset(rst), .clken(ck_en[0]), .reset_req(rreq[0]),
    .a_address(addr[0][0]), .a_byteenable(be[0][0]), .a_chipselect(cs[0][0]),
    .a_read(rd[0][0]), .a_write(wr[0][0]), .a_writedata(wd[0][0]),
    .a_readdata(rdata[0][0]), .a_readdatavalid(rvalid[0][0]),
    .a_waitrequest(wreq[0][0]), .a_parity_err(perr[0][0]),
    .b_address(addr[0][1]), .b_byteenable(be[0][1]), .b_chipselect(cs[0][1]),
    .b_read(rd[0][1]), .b_write(wr[0][1]), .b_writedata(wd[0][1]),
    .b_readdata(rdata[0][1]), .b_readdatavalid(rvalid[0][1]),
    .b_waitrequest(wreq[0][1]), .b_parity_err(perr[0][1])
  );

  multicore_shared_ram #(.DEPTH(512), .READ_LATENCY(2), .FIXED_PRIORITY(1)) u1 (
    .clk(clk), .reset(rst), .clken(ck_en[1]), .reset_req(rreq[1]),
    .a_address(addr[1][0]), .a_byteenable(be[1][0]), .a_chipselect(cs[1][0]),
    .a_read(rd[1][0]), .a_write(wr[1][0]), .a_writedata(wd[1][0]),
    .a_readdata(rdata[1][0]), .a_readdatavalid(rvalid[1][0]),
    .a_waitrequest(wreq[1][0]), .a_parity_err(perr[1][0]),
    .b_address(addr[1][1]), .b_byteenable(be[1][1]), .b_chipselect(cs[1][1]),
    .b_read(rd[1][1]), .b_write(wr[1][1]), .b_writedata(wd[1][1]),
    .b_readdata(rdata[1][1]), .b_readdatavalid(rvalid[1][1]),
    .b_waitrequest(wreq[1][1]), .b_parity_err(perr[1][1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_exp(input int k, input logic [31:0] data, input int c);
    exp_t t;
    t.data = data;
    t.cyc  = c;
    sbq[k].push_back(t);
  endtask

  // One access; returns just after its accept edge. Read expectation is due RL-1 cycles later.
  task automatic access(input int d, input int p, input logic w, input logic [9:0] a,
                        input logic [31:0] data, input logic [3:0] b, input logic [31:0] exp);
    int n = 0;
    cs[d][p] = 1'b1; rd[d][p] = ~w; wr[d][p] = w;
    addr[d][p] = a; wd[d][p] = data; be[d][p] = b;
    @(negedge clk);
    while (wreq[d][p] && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk($sformatf("grant_bound_d%0d_p%0d", d, p), 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    if (!w) push_exp(2*d + p, exp, cyc + d);
    cs[d][p] = 1'b0; rd[d][p] = 1'b0; wr[d][p] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("valid_during_reset",
          {28'd0, rvalid[1][1], rvalid[1][0], rvalid[0][1], rvalid[0][0]}, 32'd0);
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (!ck_en[d] || rreq[d])
          chk($sformatf("valid_in_stall_d%0d", d), {30'd0, rvalid[d][1], rvalid[d][0]}, 32'd0);
        for (int p = 0; p < 2; p++) begin
          if (rvalid[d][p]) begin
            chk($sformatf("expected_pending_d%0d_p%0d", d, p), 32'(sbq[2*d+p].size() > 0), 32'd1);
            if (sbq[2*d+p].size() > 0) begin
              mon_e = sbq[2*d+p].pop_front();
              chk($sformatf("rdata_d%0d_p%0d", d, p), rdata[d][p], mon_e.data);
              chk($sformatf("rcycle_d%0d_p%0d", d, p), cyc, mon_e.cyc);
              chk($sformatf("perr_d%0d_p%0d", d, p), {31'd0, perr[d][p]}, 32'd0);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_checks++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      ck_en[d] = 1'b1; rreq[d] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        cs[d][p] = 1'b0; rd[d][p] = 1'b0; wr[d][p] = 1'b0;
        addr[d][p] = '0; be[d][p] = '0; wd[d][p] = '0;
      end
    end
    repeat (3) @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        chk("reset_rdata", rdata[d][p], 32'd0);
        chk("reset_wait_idle", {31'd0, wreq[d][p]}, 32'd0);
        chk("reset_perr", {31'd0, perr[d][p]}, 32'd0);
      end
    end
    cs[0][0] = 1'b1; rd[0][0] = 1'b1; #1;
    chk("wait_during_reset", {31'd0, wreq[0][0]}, 32'd1);
    cs[0][0] = 1'b0; rd[0][0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // write then cross-port read, RL=1
    access(0, 0, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF, 32'd0);
    access(0, 1, 1'b0, 10'h005, 32'd0, 4'hF, 32'hDEADBEEF);
    repeat (2) @(posedge clk); #1;
    chk("b_readdata_hold", rdata[0][1], 32'hDEADBEEF);
    chk("a_readdata_untouched", rdata[0][0], 32'd0);

    // byte-lane merge
    access(0, 0, 1'b1, 10'h010, 32'h11223344, 4'hF, 32'd0);
    access(0, 1, 1'b1, 10'h010, 32'hAABBCCDD, 4'b0101, 32'd0);
    access(0, 0, 1'b0, 10'h010, 32'd0, 4'hF, 32'h11BB33DD);

    // round-robin: both read continuously for 6 cycles
    cs[0][0] = 1'b1; rd[0][0] = 1'b1; addr[0][0] = 10'h005; be[0][0] = 4'hF;
    cs[0][1] = 1'b1; rd[0][1] = 1'b1; addr[0][1] = 10'h010; be[0][1] = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("rr_wait_a_%0d", i), {31'd0, wreq[0][0]}, 32'(i % 2 == 1));
      chk($sformatf("rr_wait_b_%0d", i), {31'd0, wreq[0][1]}, 32'(i % 2 == 0));
      if (i % 2 == 0) push_exp(0, 32'hDEADBEEF, cyc + 1);
      else push_exp(1, 32'h11BB33DD, cyc + 1);
      @(posedge clk); #1;
    end
    cs[0][0] = 1'b0; rd[0][0] = 1'b0; cs[0][1] = 1'b0; rd[0][1] = 1'b0;

    // out-of-range on 512-word instance: write dropped, read returns zero
    access(1, 0, 1'b1, 10'h1FF, 32'h55AA55AA, 4'hF, 32'd0);
    access(1, 0, 1'b1, 10'h3FF, 32'hFFFFFFFF, 4'hF, 32'd0);
    access(1, 1, 1'b0, 10'h1FF, 32'd0, 4'hF, 32'h55AA55AA);
    access(1, 0, 1'b0, 10'h3FF, 32'd0, 4'hF, 32'h00000000);

    // fixed priority: B waits while A keeps requesting
    cs[1][0] = 1'b1; rd[1][0] = 1'b1; addr[1][0] = 10'h1FF; be[1][0] = 4'hF;
    cs[1][1] = 1'b1; rd[1][1] = 1'b1; addr[1][1] = 10'h3FF; be[1][1] = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("fp_wait_a_%0d", i), {31'd0, wreq[1][0]}, 32'd0);
      chk($sformatf("fp_wait_b_%0d", i), {31'd0, wreq[1][1]}, 32'd1);
      push_exp(2, 32'h55AA55AA, cyc + 2);
      @(posedge clk); #1;
    end
    cs[1][0] = 1'b0; rd[1][0] = 1'b0;
    @(negedge clk);
    chk("fp_b_released", {31'd0, wreq[1][1]}, 32'd0);
    push_exp(3, 32'd0, cyc + 2);
    @(posedge clk); #1;
    cs[1][1] = 1'b0; rd[1][1] = 1'b0;

    // RL=2 stream with a 3-cycle clken drop after the 2nd accept
    for (int i = 0; i < 4; i++)
      access(1, 0, 1'b1, 10'(i), 32'hA0000000 + i, 4'hF, 32'd0);
    cs[1][0] = 1'b1; rd[1][0] = 1'b1; be[1][0] = 4'hF; addr[1][0] = 10'h000;
    @(posedge clk); #1;
    k0 = cyc;
    for (int i = 0; i < 4; i++) push_exp(2, 32'hA0000000 + i, k0 + 4 + i);
    addr[1][0] = 10'h001;
    @(posedge clk); #1;
    ck_en[1] = 1'b0; addr[1][0] = 10'h002;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_wait_a", {31'd0, wreq[1][0]}, 32'd1);
      @(posedge clk); #1;
    end
    ck_en[1] = 1'b1;
    @(posedge clk); #1;
    addr[1][0] = 10'h003;
    @(posedge clk); #1;
    cs[1][0] = 1'b0; rd[1][0] = 1'b0;
    repeat (5) @(posedge clk); #1;

    // reset_req stalls like clken
    rreq[0] = 1'b1; cs[0][0] = 1'b1; rd[0][0] = 1'b1; addr[0][0] = 10'h005;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset_req_wait", {31'd0, wreq[0][0]}, 32'd1);
      @(posedge clk); #1;
    end
    rreq[0] = 1'b0;
    @(negedge clk);
    chk("reset_req_release", {31'd0, wreq[0][0]}, 32'd0);
    push_exp(0, 32'hDEADBEEF, cyc + 1);
    @(posedge clk); #1;
    cs[0][0] = 1'b0; rd[0][0] = 1'b0;

    // one contested grant (A wins) leaves prio at B
    cs[0][0] = 1'b1; rd[0][0] = 1'b1; addr[0][0] = 10'h005;
    cs[0][1] = 1'b1; rd[0][1] = 1'b1; addr[0][1] = 10'h010;
    @(negedge clk);
    chk("pre_reset_wait_b", {31'd0, wreq[0][1]}, 32'd1);
    push_exp(0, 32'hDEADBEEF, cyc + 1);
    @(posedge clk); #1;
    cs[0][0] = 1'b0; rd[0][0] = 1'b0;
    @(negedge clk);
    push_exp(1, 32'h11BB33DD, cyc + 1);
    @(posedge clk); #1;
    cs[0][1] = 1'b0; rd[0][1] = 1'b0;

    // read in flight when reset hits: must never be delivered
    cs[0][0] = 1'b1; rd[0][0] = 1'b1; addr[0][0] = 10'h010;
    @(posedge clk); #1;
    rst = 1'b1; cs[0][0] = 1'b0; rd[0][0] = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++)
        chk("post_reset_rdata", rdata[d][p], 32'd0);
    cs[0][1] = 1'b1; rd[0][1] = 1'b1; addr[0][1] = 10'h010; #1;
    chk("post_reset_immediate_grant", {31'd0, wreq[0][1]}, 32'd0);
    @(negedge clk);
    push_exp(1, 32'h11BB33DD, cyc + 1);
    @(posedge clk); #1;
    cs[0][1] = 1'b0; rd[0][1] = 1'b0;
    cs[0][0] = 1'b1; rd[0][0] = 1'b1; addr[0][0] = 10'h005;
    cs[0][1] = 1'b1; rd[0][1] = 1'b1;
    @(negedge clk);
    chk("post_reset_prio_a_wait_a", {31'd0, wreq[0][0]}, 32'd0);
    chk("post_reset_prio_a_wait_b", {31'd0, wreq[0][1]}, 32'd1);
    push_exp(0, 32'hDEADBEEF, cyc + 1);
    @(posedge clk); #1;
    cs[0][0] = 1'b0; rd[0][0] = 1'b0;
    @(negedge clk);
    push_exp(1, 32'h11BB33DD, cyc + 1);
    @(posedge clk); #1;
    cs[0][1] = 1'b0; rd[0][1] = 1'b0;

    repeat (6) @(posedge clk); #1;
    for (int k = 0; k < 4; k++)
      chk($sformatf("scoreboard_drained_%0d", k), 32'(sbq[k].size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
